// File: rtl/mcp_tx_arb_pkg.sv
// Shared types and defaults for the MCP transmit arbiter.
// Imported by the arbiter, its round-robin core and the MCP port interface.
package mcp_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 8;

    typedef logic [DW_DEF-1:0] dat_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_LO,
        WAIT_HI
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcp_tx_arb_if.sv
// Word-load handshake between the arbiter and the MCP sender.
// The master loads adatain with asend; the slave reports aready.
interface mcp_tx_if
    import mcp_arb_pkg::*;
#(
    parameter int DW = DW_DEF
) ();

    logic          aready;
    logic [DW-1:0] adatain;
    logic          asend;

    modport master (
        input  aready,
        output adatain,
        output asend
    );

    modport slave (
        output aready,
        input  adatain,
        input  asend
    );

endinterface

// File: rtl/mcp_tx_arb_rr_arbiter.sv
// Combinational round-robin picker.
// Search begins one past last_gnt and wraps around the requester set.
module rr_arbiter
    import mcp_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_gnt,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last_gnt) + k) % N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
        any = found;
    end

endmodule

// File: rtl/mcp_tx_arb.sv
// Round-robin arbiter feeding N_REQ requesters into one MCP send port.
// One word in flight; the sender's aready low/high cycle closes each transfer.
module mcp_tx_arb
    import mcp_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int DW    = DW_DEF,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic                      aclk,
    input  logic                      arst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0][DW-1:0]  req_data,
    input  logic [N_REQ-1:0]          req_en,
    output logic [N_REQ-1:0]          req_ready,
    mcp_tx_if.master                  tx,
    output logic [IW-1:0]             gnt_id,
    output logic                      busy,
    output logic [15:0]               xfer_cnt
);

    state_t           state;
    logic [IW-1:0]    last_gnt;
    logic [IW-1:0]    w_idx;
    logic [N_REQ-1:0] w_gnt;
    logic             w_any;
    logic             accept;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req      (req_valid & req_en),
        .last_gnt (last_gnt),
        .grant    (w_gnt),
        .idx      (w_idx),
        .any      (w_any)
    );

    assign accept    = (state == IDLE) && tx.aready && w_any;
    // Gated by reset so the accept pulse cannot leak while held in reset.
    assign req_ready = (arst_n && accept) ? w_gnt : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            tx.asend   <= 1'b0;
            tx.adatain <= '0;
            gnt_id     <= '0;
            xfer_cnt   <= '0;
            last_gnt   <= IW'(N_REQ - 1);
        end else begin
            tx.asend <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tx.adatain <= req_data[w_idx];
                        gnt_id     <= w_idx;
                        last_gnt   <= w_idx;
                        tx.asend   <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: state <= WAIT_LO;
                WAIT_LO: begin
                    if (!tx.aready) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx.aready) begin
                        state    <= IDLE;
                        xfer_cnt <= xfer_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mcp_tx_arb.md
MCP_TX_ARB -- requirements
Module: mcp_tx_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing one MCP send port.
REQ-002 The block SHALL have parameter DW, default 8, data width matching the MCP transmit datapath.
REQ-003 The port aclk SHALL be: input, 1 bit, source-domain clock, all logic on its rising edge.
REQ-004 The port arst_n SHALL be: input, 1 bit, reset, asynchronous, active-low.
REQ-005 The port req_valid SHALL be: input, N_REQ bits, per-requester data-valid.
REQ-006 The port req_data SHALL be: input, N_REQ x DW bits, per-requester payload.
REQ-007 The port req_en SHALL be: input, N_REQ bits, per-requester arbitration enable (configuration).
REQ-008 The port req_ready SHALL be: output, N_REQ bits, one-hot accept pulse to the winning requester.
REQ-009 The port aready SHALL be: input, 1 bit, MCP sender ready for the next word.
REQ-010 The port adatain SHALL be: output, DW bits, word to the MCP sender.
REQ-011 The port asend SHALL be: output, 1 bit, one-cycle load pulse to the MCP sender.
REQ-012 The port gnt_id SHALL be: output, clog2(N_REQ) bits, index of the requester owning the in-flight word.
REQ-013 The port busy SHALL be: output, 1 bit, high whenever state != IDLE.
REQ-014 The port xfer_cnt SHALL be: output, 16 bits, count of completed transfers.

Function
REQ-015 A requester SHALL hold req_valid and req_data stable until it sees req_ready; a transfer is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT_LO and WAIT_HI.
REQ-017 In IDLE with aready=1 and any req_valid&req_en bit set, the block SHALL pulse req_ready[w] combinationally, register req_data[w] into adatain and w into gnt_id, and go to SEND.
REQ-018 The winner w SHALL be selected round-robin: search starts at last_gnt+1 and wraps modulo N_REQ; last_gnt updates only on an accept.
REQ-019 In SEND, asend SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_LO.
REQ-020 In WAIT_LO, the FSM SHALL go to WAIT_HI on aready=0; in WAIT_HI, it SHALL go to IDLE on aready=1, and xfer_cnt SHALL increment (wrapping 0xFFFF->0) on that transition.
REQ-021 adatain and gnt_id SHALL remain stable from SEND until the next accept.
REQ-022 req_ready SHALL be 0 in every state except IDLE; at most one bit SHALL be set in any cycle.
REQ-023 A requester with req_en=0 SHALL never be granted; deasserting req_en during SEND/WAIT_* SHALL NOT abort the in-flight word.
REQ-024 With aready=0 in IDLE, no grant SHALL occur, regardless of req_valid.
REQ-025 The minimum spacing between asend pulses SHALL be 4 cycles: IDLE, SEND, WAIT_LO and WAIT_HI, each at least one cycle.

Reset
REQ-026 On arst_n=0, the block SHALL immediately force state=IDLE, asend=0, req_ready=0, adatain=0, gnt_id=0, xfer_cnt=0 and last_gnt=N_REQ-1, so requester 0 has first priority after reset.
REQ-027 A reset mid-transfer SHALL discard the in-flight word with no counter increment; the first accept after release SHALL follow REQ-017.

Structure
REQ-028 The package mcp_arb_pkg SHALL hold the FSM state enum, default N_REQ/DW and the dat_t typedef (logic [DW-1:0]).
REQ-029 Round-robin selection SHALL be in the sub-module rr_arbiter (inputs request mask and last_gnt; outputs one-hot grant and index), purely combinational.

Verification
REQ-030 Single requester: req_valid=0001, req_data[0]=0xA5, aready=1 then low 1 cycle after asend, high 3 cycles later -> req_ready=0001 once, asend one cycle with adatain=0xA5, xfer_cnt=1.
REQ-031 All four requesters continuously valid with data 0x10/0x21/0x32/0x43 -> asend order 0x10,0x21,0x32,0x43,0x10, and gnt_id sequence 0,1,2,3,0.
REQ-032 req_en=1010 with all valid -> only gnt_id 1 and 3 alternate; requesters 0 and 2 never see req_ready.
REQ-033 aready held 0 for 20 cycles in IDLE with requests pending -> no req_ready or asend; a grant occurs on the first cycle aready=1.
REQ-034 arst_n pulsed low during WAIT_HI -> all outputs at reset values; xfer_cnt unchanged from 0; the next grant goes to requester 0.
REQ-035 Preload 0xFFFF transfers (or force) then complete one more -> xfer_cnt=0x0000.
